fifo_burst_reader: RTL and testbench

Drain-side companion to the team's single-clock register FIFO. It watches the FIFO fill level, pulls fixed-length bursts through the FIFO read port (`r_req`/`r_data`/`empty`/`cnt`), and presents them downstream as a valid/ready stream with a `m_last` marker on the final beat. It supports both FIFO read flavours, first-word fall-through and registered-output. It sits between a producer-filled FIFO and a burst-oriented consumer such as a DMA or packet framer.

---
 rtl/fifo_burst_reader.sv | 108 ++++++++++
 tb/tb_fifo_burst_reader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Pulls fixed-length (or flush-length) bursts out of a register FIFO and replays them as a valid/ready stream.
// First beat 2 cycles (FWFT) or 3 cycles (registered FIFO) after start; 2-entry skid buffer, reads stall when it is full.
module fifo_burst_reader #(
   parameter string FWFT_MODE = "TRUE",
   parameter int    DATA_W    = 32,
   parameter int    DEPTH_W   = 4,
   parameter int    BURST_LEN = 4
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               f_empty,
   input  logic [DEPTH_W-1:0] f_cnt,
   input  logic [DATA_W-1:0]  f_r_data,
   output logic               f_r_req,
   input  logic               flush,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [DATA_W-1:0]  m_data,
   output logic               m_last,
   output logic               busy,
   output logic               fail
);

   localparam bit                 FWFT      = (FWFT_MODE == "TRUE");
   localparam logic [DEPTH_W-1:0] BLEN_FULL = DEPTH_W'(BURST_LEN);
   localparam logic [DEPTH_W-1:0] ONE       = DEPTH_W'(1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t             state, state_nxt;
   logic               start;
   logic [DEPTH_W-1:0] load_len;
   logic [DEPTH_W-1:0] iss_left, out_left;
   logic [1:0]         occ;
   logic               infl;
   logic [DATA_W-1:0]  buf_dat [2];
   logic               wr_ptr, rd_ptr;
   logic               pop, push, space, want_rd;

   always_ff @(posedge clk) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      load_len  = BLEN_FULL;
      case (state)
         IDLE: begin
            if (f_cnt >= BLEN_FULL) begin
               start = 1'b1;
            end else if (flush && !f_empty && (f_cnt != '0)) begin
               start    = 1'b1;
               load_len = f_cnt;
            end
            if (start) state_nxt = BURST;
         end
         BURST: begin
            if (pop && m_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Space check counts the word still in flight from a registered FIFO and
   // credits a pop happening this cycle, so the buffer never exceeds two.
   assign pop     = m_valid & m_ready;
   assign space   = ({1'b0, occ} + {2'b00, infl}) < (3'd2 + {2'b00, pop});
   assign busy    = (state == BURST);
   assign want_rd = busy & (iss_left != '0) & space;
   assign f_r_req = want_rd & !f_empty;
   assign fail    = want_rd & f_empty;
   assign push    = FWFT ? f_r_req : infl;

   assign m_valid = (occ != 2'd0);
   assign m_data  = buf_dat[rd_ptr];
   assign m_last  = m_valid & (out_left == ONE);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         iss_left   <= '0;
         out_left   <= '0;
         occ        <= 2'd0;
         infl       <= 1'b0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         buf_dat[0] <= '0;
         buf_dat[1] <= '0;
      end else begin
         if (start) begin
            iss_left <= load_len;
            out_left <= load_len;
         end else begin
            if (f_r_req) iss_left <= iss_left - ONE;
            if (pop)     out_left <= out_left - ONE;
         end
         infl <= FWFT ? 1'b0 : f_r_req;
         if (push) begin
            buf_dat[wr_ptr] <= f_r_data;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Runs an FWFT and a registered-output instance side by side on identical FIFO contents;
// expected beats come from a burst-partition model of the written words.
module tb_fifo_burst_reader;

   localparam int BL = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        nrst = 1'b0, flush = 1'b0, m_ready = 1'b0, steal = 1'b0, fifo_clr = 1'b0;

   logic [31:0] mem [256];
   logic [7:0]  wp = 8'd0, rp0 = 8'd0, rp1 = 8'd0;
   logic [31:0] rdq1 = 32'd0;

   logic        f_empty0, f_empty1, f_r_req0, f_r_req1;
   logic [3:0]  f_cnt0, f_cnt1;
   logic [31:0] f_r_data0, f_r_data1, m_data0, m_data1;
   logic        m_valid0, m_valid1, m_last0, m_last1, busy0, busy1, fail0, fail1;

   logic [1:0]        vld_v, lst_v, req_v, bsy_v, fl_v;
   logic [1:0][31:0]  dat_v;
   assign vld_v = {m_valid1, m_valid0};
   assign lst_v = {m_last1, m_last0};
   assign req_v = {f_r_req1, f_r_req0};
   assign bsy_v = {busy1, busy0};
   assign fl_v  = {fail1, fail0};
   assign dat_v = {m_data1, m_data0};

   // FIFO models: one first-word fall-through, one registered output
   assign f_cnt0    = 4'(wp - rp0);
   assign f_cnt1    = 4'(wp - rp1);
   assign f_empty0  = (wp == rp0) | steal;
   assign f_empty1  = (wp == rp1) | steal;
   assign f_r_data0 = mem[rp0];
   assign f_r_data1 = rdq1;

   always @(posedge clk) begin
      if (fifo_clr)      rp0 <= wp;
      else if (f_r_req0) rp0 <= rp0 + 8'd1;
   end

   always @(posedge clk) begin
      if (fifo_clr) rp1 <= wp;
      else if (f_r_req1) begin
         rp1  <= rp1 + 8'd1;
         rdq1 <= mem[rp1];
      end
   end

   fifo_burst_reader #(.FWFT_MODE("TRUE"), .DATA_W(32), .DEPTH_W(4), .BURST_LEN(BL)) u_fwft (
      .clk(clk), .nrst(nrst), .f_empty(f_empty0), .f_cnt(f_cnt0), .f_r_data(f_r_data0),
      .f_r_req(f_r_req0), .flush(flush), .m_valid(m_valid0), .m_ready(m_ready),
      .m_data(m_data0), .m_last(m_last0), .busy(busy0), .fail(fail0));

   fifo_burst_reader #(.FWFT_MODE("FALSE"), .DATA_W(32), .DEPTH_W(4), .BURST_LEN(BL)) u_norm (
      .clk(clk), .nrst(nrst), .f_empty(f_empty1), .f_cnt(f_cnt1), .f_r_data(f_r_data1),
      .f_r_req(f_r_req1), .flush(flush), .m_valid(m_valid1), .m_ready(m_ready),
      .m_data(m_data1), .m_last(m_last1), .busy(busy1), .fail(fail1));

   int vectors = 0, miscompares = 0;

   // Expected stream {last, data}; each instance walks it with its own index
   logic [32:0] exp_mem [$];
   int          exp_idx [2];
   bit          stalled [2];
   logic [31:0] held_d  [2];
   logic        held_l  [2];

   initial begin
      exp_idx[0] = 0; exp_idx[1] = 0;
      stalled[0] = 0; stalled[1] = 0;
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!nrst) begin
            stalled[d] = 1'b0;
         end else begin
            if (stalled[d]) begin
               vectors++;
               if (!vld_v[d] || dat_v[d] !== held_d[d] || lst_v[d] !== held_l[d]) begin
                  miscompares++;
                  $display("FAIL hold dut%0d: valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                           d, vld_v[d], dat_v[d], lst_v[d], held_d[d], held_l[d]);
               end
            end
            if (vld_v[d] && m_ready) begin
               vectors++;
               if (exp_idx[d] >= exp_mem.size()) begin
                  miscompares++;
                  $display("FAIL extra_beat dut%0d: data=%h last=%0b, required no beat", d, dat_v[d], lst_v[d]);
               end else begin
                  if (dat_v[d] !== exp_mem[exp_idx[d]][31:0] || lst_v[d] !== exp_mem[exp_idx[d]][32]) begin
                     miscompares++;
                     $display("FAIL beat dut%0d #%0d: data=%h last=%0b, required data=%h last=%0b",
                              d, exp_idx[d], dat_v[d], lst_v[d], exp_mem[exp_idx[d]][31:0], exp_mem[exp_idx[d]][32]);
                  end
                  exp_idx[d]++;
               end
            end
            stalled[d] = vld_v[d] & !m_ready;
            held_d[d]  = dat_v[d];
            held_l[d]  = lst_v[d];
         end
      end
   end

   // mode 0: base+i, 1: random, 2: base*(i+1). Bursts are BL words; a flush
   // leaves a short final burst, so last falls on every BL-th word and the tail.
   task automatic put_words(input int n, input logic [31:0] base, input int mode, input bit fl);
      logic [31:0] w;
      bit          last;
      for (int i = 0; i < n; i++) begin
         case (mode)
            1:       w = $urandom;
            2:       w = base * 32'(i + 1);
            default: w = base + 32'(i);
         endcase
         last = ((i % BL) == BL - 1) || (fl && i == n - 1);
         mem[wp] = w;
         wp      = wp + 8'd1;
         exp_mem.push_back({last, w});
      end
   endtask

   task automatic wait_done(input bit rnd_rdy, input int budget);
      int c = 0;
      bit done = 1'b0;
      while (!done && c < budget) begin
         @(posedge clk); #1;
         m_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         done = (bsy_v == 2'b00) && (rp0 == wp) && (rp1 == wp) &&
                (exp_idx[0] == exp_mem.size()) && (exp_idx[1] == exp_mem.size());
         c++;
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL drain: not finished after %0d cycles busy=%b, required idle with all beats delivered", c, bsy_v);
      end
   endtask

   task automatic test_reset;
      nrst = 1'b0;
      repeat (3) @(posedge clk);
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         vectors++;
         if ({vld_v, lst_v, req_v, bsy_v, fl_v} !== 10'd0 || dat_v !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_%0d: valid=%b last=%b req=%b busy=%b fail=%b data=%h, required all 0",
                     r, vld_v, lst_v, req_v, bsy_v, fl_v, dat_v);
         end
         @(posedge clk); #1;
         nrst = 1'b1;
      end
   endtask

   task automatic test_timing;
      int first;
      bit e_req, e_v, e_busy;
      @(posedge clk); #1;
      m_ready = 1'b1;
      flush   = 1'b0;
      put_words(4, 32'hA0, 0, 0);
      for (int j = 1; j <= 7; j++) begin
         @(posedge clk); #1;
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            first  = (d == 0) ? 2 : 3;
            e_req  = (j <= 4);
            e_v    = (j >= first) && (j <= first + 3);
            e_busy = (j <= first + 3);
            vectors++;
            if (req_v[d] !== e_req || vld_v[d] !== e_v || bsy_v[d] !== e_busy) begin
               miscompares++;
               $display("FAIL timing dut%0d k+%0d: req=%0b valid=%0b busy=%0b, required req=%0b valid=%0b busy=%0b",
                        d, j, req_v[d], vld_v[d], bsy_v[d], e_req, e_v, e_busy);
            end
            if (e_v) begin
               vectors++;
               if (dat_v[d] !== 32'hA0 + 32'(j - first) || lst_v[d] !== (j == first + 3)) begin
                  miscompares++;
                  $display("FAIL timing_data dut%0d k+%0d: data=%h last=%0b, required data=%h last=%0b",
                           d, j, dat_v[d], lst_v[d], 32'hA0 + 32'(j - first), (j == first + 3));
               end
            end
         end
      end
      wait_done(0, 20);
   endtask

   task automatic test_empty_flush;
      @(posedge clk); #1;
      flush = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(posedge clk); #1;
         @(negedge clk);
         vectors++;
         if (bsy_v !== 2'b00 || req_v !== 2'b00) begin
            miscompares++;
            $display("FAIL empty_flush: busy=%b req=%b, required busy=00 req=00", bsy_v, req_v);
         end
      end
      flush = 1'b0;
   endtask

   task automatic test_flush;
      @(posedge clk); #1;
      flush   = 1'b1;
      m_ready = 1'b1;
      put_words(3, 32'h11, 2, 1);
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (bsy_v !== 2'b11) begin
         miscompares++;
         $display("FAIL flush_start: busy=%b, required 11", bsy_v);
      end
      wait_done(0, 30);
      flush = 1'b0;
   endtask

   task automatic test_backpressure;
      int  lasts0 = 0, lasts1 = 0, c = 0;
      bit  done = 1'b0;
      @(posedge clk); #1;
      m_ready = 1'b1;
      put_words(8, 32'h40, 0, 0);
      while (!done && c < 100) begin
         @(posedge clk); #1;
         m_ready = ((c % 4) == 0) || ((c % 4) == 3);
         @(negedge clk);
         if (m_valid0 && m_ready && m_last0) lasts0++;
         if (m_valid1 && m_ready && m_last1) lasts1++;
         done = (bsy_v == 2'b00) && (exp_idx[0] == exp_mem.size()) && (exp_idx[1] == exp_mem.size());
         c++;
      end
      vectors++;
      if (!done || lasts0 != 2 || lasts1 != 2) begin
         miscompares++;
         $display("FAIL backpressure: done=%0b lasts=%0d/%0d, required done=1 lasts=2/2", done, lasts0, lasts1);
      end
   endtask

   task automatic test_stolen;
      @(posedge clk); #1;
      m_ready = 1'b1;
      put_words(4, 32'hC0, 0, 0);
      for (int j = 1; j <= 5; j++) begin
         @(posedge clk); #1;
         steal = (j >= 2) && (j <= 4);
         @(negedge clk);
         vectors++;
         if (fl_v !== {2{steal}} || (steal && req_v !== 2'b00)) begin
            miscompares++;
            $display("FAIL stolen k+%0d: fail=%b req=%b, required fail=%b req=00 while stolen",
                     j, fl_v, req_v, {2{steal}});
         end
      end
      steal = 1'b0;
      wait_done(0, 30);
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      m_ready = 1'b1;
      put_words(4, 32'hD0, 0, 0);
      repeat (3) begin
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      nrst       = 1'b0;
      exp_idx[0] = exp_mem.size();
      exp_idx[1] = exp_mem.size();
      @(posedge clk); #1;
      nrst     = 1'b1;
      fifo_clr = 1'b1;
      @(negedge clk);
      vectors++;
      if ({vld_v, lst_v, req_v, bsy_v, fl_v} !== 10'd0 || dat_v !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_mid: valid=%b last=%b req=%b busy=%b fail=%b data=%h, required all 0",
                  vld_v, lst_v, req_v, bsy_v, fl_v, dat_v);
      end
      @(posedge clk); #1;
      fifo_clr = 1'b0;
      put_words(4, 32'hE0, 0, 0);
      wait_done(0, 30);
   endtask

   task automatic test_random;
      int n;
      for (int it = 0; it < 8; it++) begin
         @(posedge clk); #1;
         n     = $urandom_range(1, 15);
         flush = 1'b1;
         put_words(n, 32'd0, 1, 1);
         wait_done(1, 400);
         flush = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_timing;
      test_empty_flush;
      test_flush;
      test_backpressure;
      test_stolen;
      test_reset_mid;
      test_random;
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
